// File: rtl/fft_pkg.sv
// Shared FFT definitions: stage-sequencer state encoding and size helpers used by the AGU,
// twiddle ROM and butterfly.
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } agu_state_e;

  function automatic int unsigned log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned span(input int unsigned n, input int unsigned stage);
    return n >> (stage + 1);
  endfunction

  // Twiddle index width; the last stage has a single twiddle but keeps a 1-bit port.
  function automatic int unsigned tw_width(input int unsigned n, input int unsigned stage);
    int unsigned w;
    w = log2n(n) - stage - 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Free-running, reset-clearable shift register aligning write-back info with the butterfly result.
module fft_delay_line #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [LAT];
  logic [W-1:0] pipe_d [LAT];

  always_comb begin
    pipe_d[0] = d_i;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign q_o = pipe_q[LAT-1];

endmodule

// File: rtl/fft_stage_agu.sv
// Radix-2 DIF stage address generator: walks groups/butterflies, issues read pairs with twiddle
// index, and replays the addresses as write-back once the butterfly result is ready.
module fft_stage_agu
  import fft_pkg::*;
#(
  parameter int unsigned FFT_N    = 1024,
  parameter int unsigned STAGE_NO = 0,
  parameter int unsigned PIPE_LAT = 4,
  localparam int unsigned LOG2N   = log2n(FFT_N),
  localparam int unsigned TW_W    = tw_width(FFT_N, STAGE_NO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pair_ready,
  output logic             pair_valid,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [TW_W-1:0]  tw_addr,
  output logic             last_pair,
  output logic             wr_valid,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SPAN     = span(FFT_N, STAGE_NO);
  localparam int unsigned SPAN_LOG = LOG2N - STAGE_NO - 1;
  localparam int unsigned JW       = TW_W;
  localparam int unsigned GW       = (STAGE_NO > 0) ? STAGE_NO : 1;
  localparam int unsigned DW       = 2 * LOG2N + 2;

  localparam logic [JW-1:0]    JMax     = JW'(SPAN - 1);
  localparam logic [GW-1:0]    GMax     = GW'((1 << STAGE_NO) - 1);
  localparam logic [LOG2N-1:0] SpanAddr = LOG2N'(SPAN);

  agu_state_e state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [GW-1:0] g_q, g_d;
  logic pair_valid_q, pair_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             hs;
  logic             is_last;
  logic [LOG2N-1:0] a_full;
  logic [LOG2N-1:0] b_full;
  logic [DW-1:0]    dly_in;
  logic [DW-1:0]    dly_out;
  logic             wr_last;

  assign hs      = pair_valid_q & pair_ready;
  assign is_last = (j_q == JMax) && (g_q == GMax);

  // a = g*2*span + j built by shift/OR: bit SPAN_LOG of a is always 0, so b = a | span.
  always_comb begin
    a_full = (LOG2N'(g_q) << (SPAN_LOG + 1)) | LOG2N'(j_q);
    b_full = a_full | SpanAddr;
  end

  always_comb begin
    j_d = j_q;
    g_d = g_q;
    if (hs) begin
      if (j_q == JMax) begin
        j_d = '0;
        g_d = (g_q == GMax) ? '0 : g_q + GW'(1);
      end else begin
        j_d = j_q + JW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (hs && is_last) state_d = StDrain;
      StDrain: if (wr_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    pair_valid_d = (state_d == StRun);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      j_q          <= '0;
      g_q          <= '0;
      pair_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      j_q          <= j_d;
      g_q          <= g_d;
      pair_valid_q <= pair_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Addresses are zeroed when not handshaking so idle write-back outputs stay at 0.
  assign dly_in = {hs, hs & is_last, hs ? a_full : '0, hs ? b_full : '0};

  fft_delay_line #(
    .W  (DW),
    .LAT(PIPE_LAT)
  ) u_wr_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (dly_in),
    .q_o  (dly_out)
  );

  assign wr_valid  = dly_out[DW-1];
  assign wr_last   = dly_out[DW-2];
  assign wr_addr_a = dly_out[2*LOG2N-1:LOG2N];
  assign wr_addr_b = dly_out[LOG2N-1:0];

  assign pair_valid = pair_valid_q;
  assign rd_addr_a  = pair_valid_q ? a_full : '0;
  assign rd_addr_b  = pair_valid_q ? b_full : '0;
  assign last_pair  = pair_valid_q & is_last;
  assign busy       = busy_q;
  assign done       = done_q;

  if (SPAN == 1) begin : g_tw_tied
    assign tw_addr = '0;
  end else begin : g_tw_cnt
    assign tw_addr = pair_valid_q ? j_q : '0;
  end

endmodule
